// File: rtl/adj_request_arbiter_pkg.sv
// Shared types and widths for the adjustment-port arbiter.
// Contains the request type and FSM state enums and the field widths.
package adj_request_arbiter_pkg;

    localparam int SecondWidth_Con             = 32;
    localparam int NanosecondWidth_Con         = 32;
    localparam int AdjustmentIntervalWidth_Con = 32;
    localparam int AdjTimeoutCycles_Con        = 1024;

    typedef enum logic [1:0] {
        TimeSet_E = 2'd0,
        Offset_E  = 2'd1,
        Drift_E   = 2'd2,
        Invalid_E = 2'd3
    } Adj_Type_Type;

    typedef enum logic [1:0] {
        ArbIdle_St  = 2'd0,
        ArbIssue_St = 2'd1,
        ArbWait_St  = 2'd2,
        ArbDone_St  = 2'd3
    } Arb_State_Type;

    localparam Arb_State_Type ArbReset_Con = ArbIdle_St;

endpackage

// File: rtl/adj_request_arbiter_if.sv
// Bundle of requester-side and clock-side signals of the adjustment arbiter.
// slave = arbiter view, master = environment (requesters + clock) view.
interface adj_request_arbiter_if #(
    parameter int NumReq_Gen = 3
);
    import adj_request_arbiter_pkg::*;

    logic [NumReq_Gen-1:0]                             Enable_DatIn;
    logic [NumReq_Gen-1:0]                             Req_ValIn;
    logic [2*NumReq_Gen-1:0]                           Req_TypeIn;
    logic [SecondWidth_Con*NumReq_Gen-1:0]             Req_SecondIn;
    logic [NanosecondWidth_Con*NumReq_Gen-1:0]         Req_NanosecondIn;
    logic [NumReq_Gen-1:0]                             Req_SignIn;
    logic [AdjustmentIntervalWidth_Con*NumReq_Gen-1:0] Req_IntervalIn;
    logic [NumReq_Gen-1:0]                             Req_AckOut;
    logic [NumReq_Gen-1:0]                             Req_ErrOut;

    logic                                   Adj_ValOut;
    logic [1:0]                             Adj_TypeOut;
    logic [SecondWidth_Con-1:0]             Adj_SecondOut;
    logic [NanosecondWidth_Con-1:0]         Adj_NanosecondOut;
    logic                                   Adj_SignOut;
    logic [AdjustmentIntervalWidth_Con-1:0] Adj_IntervalOut;
    logic                                   Adj_AckIn;

    logic                  Busy_DatOut;
    logic [NumReq_Gen-1:0] Grant_DatOut;

    modport slave (
        input  Enable_DatIn, Req_ValIn, Req_TypeIn, Req_SecondIn, Req_NanosecondIn,
               Req_SignIn, Req_IntervalIn, Adj_AckIn,
        output Req_AckOut, Req_ErrOut, Adj_ValOut, Adj_TypeOut, Adj_SecondOut,
               Adj_NanosecondOut, Adj_SignOut, Adj_IntervalOut, Busy_DatOut, Grant_DatOut
    );

    modport master (
        output Enable_DatIn, Req_ValIn, Req_TypeIn, Req_SecondIn, Req_NanosecondIn,
               Req_SignIn, Req_IntervalIn, Adj_AckIn,
        input  Req_AckOut, Req_ErrOut, Adj_ValOut, Adj_TypeOut, Adj_SecondOut,
               Adj_NanosecondOut, Adj_SignOut, Adj_IntervalOut, Busy_DatOut, Grant_DatOut
    );

endinterface

// File: rtl/adj_request_arbiter_picker.sv
// Combinational winner selection for the adjustment arbiter.
// ROUND_ROBIN_EN: search upward from ptr+1 with wrap; otherwise lowest index wins.
module adj_req_picker #(
    parameter int NumReq_Gen = 3
) (
    input  logic [NumReq_Gen-1:0]         cand,
`ifdef ROUND_ROBIN_EN
    input  logic [$clog2(NumReq_Gen)-1:0] ptr,
`endif
    output logic                          any,
    output logic [NumReq_Gen-1:0]         win,
    output logic [$clog2(NumReq_Gen)-1:0] win_idx
);
    localparam int IdxW = $clog2(NumReq_Gen);

    always_comb begin
        any     = 1'b0;
        win     = '0;
        win_idx = '0;
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= NumReq_Gen; k++) begin
            int i;
            i = (int'(ptr) + k) % NumReq_Gen;
            if (!any && cand[i]) begin
                any     = 1'b1;
                win[i]  = 1'b1;
                win_idx = IdxW'(i);
            end
        end
`else
        for (int i = 0; i < NumReq_Gen; i++) begin
            if (!any && cand[i]) begin
                any     = 1'b1;
                win[i]  = 1'b1;
                win_idx = IdxW'(i);
            end
        end
`endif
    end

endmodule

// File: rtl/adj_request_arbiter.sv
// Shares the adjustable clock's single adjustment port between several requesters.
// Optional ROUND_ROBIN_EN selects rotating priority instead of lowest-index-first.
module adj_request_arbiter
    import adj_request_arbiter_pkg::*;
#(
    parameter int NumReq_Gen        = 3,
    parameter int TimeoutCycles_Gen = AdjTimeoutCycles_Con
) (
    input logic                  SysClk_ClkIn,
    input logic                  SysRstN_RstIn,
    adj_request_arbiter_if.slave bus
);
    localparam int IdxW = $clog2(NumReq_Gen);
    localparam int CntW = $clog2(TimeoutCycles_Gen);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles_Gen - 1);

    Arb_State_Type         state;
    logic [CntW-1:0]       tmo_cnt;
    logic [NumReq_Gen-1:0] cand;
    logic [NumReq_Gen-1:0] win;
    logic                  any;
    logic [IdxW-1:0]       win_idx;
    Adj_Type_Type          win_type;
`ifdef ROUND_ROBIN_EN
    logic [IdxW-1:0]       rr_ptr;
`endif

    assign cand     = bus.Req_ValIn & bus.Enable_DatIn;
    assign win_type = Adj_Type_Type'(bus.Req_TypeIn[int'(win_idx)*2 +: 2]);

    adj_req_picker #(
        .NumReq_Gen(NumReq_Gen)
    ) u_picker (
        .cand    (cand),
`ifdef ROUND_ROBIN_EN
        .ptr     (rr_ptr),
`endif
        .any     (any),
        .win     (win),
        .win_idx (win_idx)
    );

    // Every output is registered; strobes and completion pulses are set on the
    // transition into the state they belong to so they appear in that state's cycle.
    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            state                 <= ArbReset_Con;
            tmo_cnt               <= '0;
            bus.Req_AckOut        <= '0;
            bus.Req_ErrOut        <= '0;
            bus.Adj_ValOut        <= 1'b0;
            bus.Adj_TypeOut       <= '0;
            bus.Adj_SecondOut     <= '0;
            bus.Adj_NanosecondOut <= '0;
            bus.Adj_SignOut       <= 1'b0;
            bus.Adj_IntervalOut   <= '0;
            bus.Busy_DatOut       <= 1'b0;
            bus.Grant_DatOut      <= '0;
`ifdef ROUND_ROBIN_EN
            rr_ptr                <= IdxW'(NumReq_Gen - 1);
`endif
        end else begin
            bus.Adj_ValOut <= 1'b0;
            bus.Req_AckOut <= '0;
            bus.Req_ErrOut <= '0;
            case (state)
                ArbIdle_St: begin
                    if (any) begin
                        bus.Grant_DatOut      <= win;
                        bus.Busy_DatOut       <= 1'b1;
                        bus.Adj_TypeOut       <= win_type;
                        bus.Adj_SecondOut     <= bus.Req_SecondIn[int'(win_idx)*SecondWidth_Con +: SecondWidth_Con];
                        bus.Adj_NanosecondOut <= bus.Req_NanosecondIn[int'(win_idx)*NanosecondWidth_Con +: NanosecondWidth_Con];
                        bus.Adj_SignOut       <= bus.Req_SignIn[win_idx];
                        bus.Adj_IntervalOut   <= bus.Req_IntervalIn[int'(win_idx)*AdjustmentIntervalWidth_Con +: AdjustmentIntervalWidth_Con];
`ifdef ROUND_ROBIN_EN
                        rr_ptr                <= win_idx;
`endif
                        if (win_type == Invalid_E) begin
                            bus.Req_ErrOut <= win;
                            state          <= ArbDone_St;
                        end else begin
                            bus.Adj_ValOut <= 1'b1;
                            state          <= ArbIssue_St;
                        end
                    end
                end
                ArbIssue_St: begin
                    tmo_cnt <= '0;
                    state   <= ArbWait_St;
                end
                ArbWait_St: begin
                    // Ack takes precedence over a timeout landing on the same cycle.
                    if (bus.Adj_AckIn) begin
                        bus.Req_AckOut <= bus.Grant_DatOut;
                        state          <= ArbDone_St;
                    end else if (tmo_cnt == TimeoutLast) begin
                        bus.Req_ErrOut <= bus.Grant_DatOut;
                        state          <= ArbDone_St;
                    end else begin
                        tmo_cnt <= tmo_cnt + CntW'(1);
                    end
                end
                ArbDone_St: begin
                    bus.Grant_DatOut <= '0;
                    bus.Busy_DatOut  <= 1'b0;
                    state            <= ArbIdle_St;
                end
                default: state <= ArbReset_Con;
            endcase
        end
    end

endmodule

// File: tb/tb_adj_request_arbiter.sv
// Self-checking bench for adj_request_arbiter: directed scenarios plus a randomized
// run against a transaction-level schedule model.
`timescale 1ns/1ps
module tb_adj_request_arbiter;
    import adj_request_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int T  = 16;
    localparam int RC = 700;
    localparam int AL = RC + 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adj_request_arbiter_if #(.NumReq_Gen(N)) bus ();

    adj_request_arbiter #(
        .NumReq_Gen        (N),
        .TimeoutCycles_Gen (T)
    ) dut (
        .SysClk_ClkIn  (clk),
        .SysRstN_RstIn (rst_n),
        .bus           (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [N-1:0] val = '0;
    logic [N-1:0] en  = '1;
    logic [N-1:0] sgn = '0;
    logic         ack = 1'b0;
    logic [1:0]   typ [N];
    logic [31:0]  sec [N];
    logic [31:0]  ns  [N];
    logic [31:0]  iv  [N];

    always_comb begin
        bus.Req_ValIn        = val;
        bus.Enable_DatIn     = en;
        bus.Req_SignIn       = sgn;
        bus.Adj_AckIn        = ack;
        bus.Req_TypeIn       = '0;
        bus.Req_SecondIn     = '0;
        bus.Req_NanosecondIn = '0;
        bus.Req_IntervalIn   = '0;
        for (int i = 0; i < N; i++) begin
            bus.Req_TypeIn[i*2 +: 2]         = typ[i];
            bus.Req_SecondIn[i*32 +: 32]     = sec[i];
            bus.Req_NanosecondIn[i*32 +: 32] = ns[i];
            bus.Req_IntervalIn[i*32 +: 32]   = iv[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] t, input logic [31:0] s,
                           input logic [31:0] n, input logic sg, input logic [31:0] v);
        val[i] = 1'b1;
        typ[i] = t;
        sec[i] = s;
        ns[i]  = n;
        sgn[i] = sg;
        iv[i]  = v;
    endtask

    // Leaves the bench at the start of "cycle 0" with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        val   = '0;
        ack   = 1'b0;
        en    = '1;
        tick();
        tick();
        chk("rst_busy",  bus.Busy_DatOut,   0);
        chk("rst_grant", bus.Grant_DatOut,  0);
        chk("rst_val",   bus.Adj_ValOut,    0);
        chk("rst_ack",   bus.Req_AckOut,    0);
        chk("rst_err",   bus.Req_ErrOut,    0);
        chk("rst_sec",   bus.Adj_SecondOut, 0);
        rst_n = 1'b1;
    endtask

    logic [N-1:0] e_val   [AL];
    logic [N-1:0] e_ack   [AL];
    logic [N-1:0] e_err   [AL];
    logic [N-1:0] e_grant [AL];
    logic [1:0]   e_typ   [AL];
    logic [31:0]  e_sec   [AL];
    logic [31:0]  e_ns    [AL];
    logic [31:0]  e_iv    [AL];
    logic         e_sgn   [AL];
    logic         a_plan  [AL];
    int           done_at [N];
    int           w, d, lat, free_at, win_lo, win_hi, ptr;
    logic [N-1:0] cand, oh;

    initial begin
        for (int i = 0; i < N; i++) begin
            typ[i] = 2'd0; sec[i] = '0; ns[i] = '0; iv[i] = '0;
        end

        // Single offset request from requester 1, ack one cycle after the strobe.
        do_reset();
        set_req(1, 2'd1, 32'd0, 32'd500, 1'b0, 32'd1000000);
        tick();
        chk("single_val",   bus.Adj_ValOut,        1);
        chk("single_type",  bus.Adj_TypeOut,       1);
        chk("single_sec",   bus.Adj_SecondOut,     0);
        chk("single_ns",    bus.Adj_NanosecondOut, 500);
        chk("single_iv",    bus.Adj_IntervalOut,   1000000);
        chk("single_grant", bus.Grant_DatOut,      3'b010);
        chk("single_busy",  bus.Busy_DatOut,       1);
        tick();
        chk("single_val_c2", bus.Adj_ValOut, 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("single_ack",    bus.Req_AckOut, 3'b010);
        chk("single_noerr",  bus.Req_ErrOut, 0);
        tick();
        val[1] = 1'b0;
        chk("single_idle",   bus.Busy_DatOut,  0);
        chk("single_gclr",   bus.Grant_DatOut, 0);
        chk("single_ackclr", bus.Req_AckOut,   0);
        chk("single_hold",   bus.Adj_NanosecondOut, 500);

        // Contention between 0 and 2: 0 first, then 2 once 0 drops.
        do_reset();
        set_req(0, 2'd1, 32'd11, 32'd12, 1'b0, 32'd13);
        set_req(2, 2'd2, 32'd21, 32'd22, 1'b1, 32'd23);
        tick();
        chk("cont_g0", bus.Grant_DatOut, 3'b001);
        chk("cont_t0", bus.Adj_TypeOut, 1);
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("cont_a0", bus.Req_AckOut, 3'b001);
        tick();
        val[0] = 1'b0;
        tick();
        chk("cont_g2",  bus.Grant_DatOut, 3'b100);
        chk("cont_v2",  bus.Adj_ValOut, 1);
        chk("cont_s2",  bus.Adj_SecondOut, 21);
        chk("cont_sg2", bus.Adj_SignOut, 1);
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("cont_a2", bus.Req_AckOut, 3'b100);
        tick();
        val[2] = 1'b0;

        // Timeout: no ack ever arrives.
        do_reset();
        set_req(0, 2'd0, 32'd5, 32'd6, 1'b1, 32'd0);
        tick();
        chk("tmo_val", bus.Adj_ValOut, 1);
        repeat (16) tick();
        chk("tmo_early", bus.Req_ErrOut, 0);
        chk("tmo_busy",  bus.Busy_DatOut, 1);
        tick();
        chk("tmo_err",   bus.Req_ErrOut, 3'b001);
        chk("tmo_noack", bus.Req_AckOut, 0);
        tick();
        val[0] = 1'b0;
        chk("tmo_idle", bus.Busy_DatOut, 0);

        // Invalid type is rejected without a strobe.
        do_reset();
        set_req(0, 2'd3, 32'd7, 32'd8, 1'b0, 32'd9);
        tick();
        chk("inv_err",   bus.Req_ErrOut, 3'b001);
        chk("inv_noval", bus.Adj_ValOut, 0);
        chk("inv_grant", bus.Grant_DatOut, 3'b001);
        tick();
        val[0] = 1'b0;
        chk("inv_noval2", bus.Adj_ValOut, 0);
        chk("inv_idle",   bus.Busy_DatOut, 0);

        // Masked requester ignored; disabling the winner mid-wait does not cancel it.
        do_reset();
        en = 3'b110;
        set_req(0, 2'd1, 32'd1, 32'd2, 1'b0, 32'd3);
        repeat (3) begin
            tick();
            chk("mask_nobusy", bus.Busy_DatOut, 0);
        end
        set_req(1, 2'd2, 32'd4, 32'd5, 1'b0, 32'd6);
        tick();
        chk("mask_g1", bus.Grant_DatOut, 3'b010);
        tick();
        en = 3'b100;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("mask_ack1", bus.Req_AckOut, 3'b010);
        tick();
        val = '0;
        chk("mask_idle", bus.Busy_DatOut, 0);

        // Reset in Wait clears everything at once; pending request re-granted afterwards.
        do_reset();
        set_req(2, 2'd0, 32'hABCD, 32'd77, 1'b1, 32'd88);
        tick();
        chk("rw_val", bus.Adj_ValOut, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rw_busy",  bus.Busy_DatOut,  0);
        chk("rw_grant", bus.Grant_DatOut, 0);
        chk("rw_sec",   bus.Adj_SecondOut, 0);
        chk("rw_sign",  bus.Adj_SignOut,  0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rw_regrant", bus.Grant_DatOut, 3'b100);
        chk("rw_reval",   bus.Adj_ValOut, 1);
        chk("rw_resec",   bus.Adj_SecondOut, 32'hABCD);
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("rw_ack", bus.Req_AckOut, 3'b100);
        tick();
        val[2] = 1'b0;

        // Randomized run against a precomputed per-cycle schedule.
        for (int c = 0; c < AL; c++) begin
            e_val[c] = '0; e_ack[c] = '0; e_err[c] = '0; e_grant[c] = '0;
            e_typ[c] = '0; e_sec[c] = '0; e_ns[c] = '0; e_iv[c] = '0;
            e_sgn[c] = 1'b0; a_plan[c] = 1'b0;
        end
        for (int i = 0; i < N; i++) done_at[i] = -10;
        free_at = 0; win_lo = -1; win_hi = -1; ptr = N - 1;
        do_reset();
        for (int cyc = 0; cyc < RC; cyc++) begin
            chk("rnd_val",   bus.Adj_ValOut,   e_val[cyc] != 0);
            chk("rnd_ack",   bus.Req_AckOut,   e_ack[cyc]);
            chk("rnd_err",   bus.Req_ErrOut,   e_err[cyc]);
            chk("rnd_grant", bus.Grant_DatOut, e_grant[cyc]);
            chk("rnd_busy",  bus.Busy_DatOut,  e_grant[cyc] != 0);
            if (e_val[cyc] != 0) begin
                chk("rnd_type", bus.Adj_TypeOut,       e_typ[cyc]);
                chk("rnd_sec",  bus.Adj_SecondOut,     e_sec[cyc]);
                chk("rnd_ns",   bus.Adj_NanosecondOut, e_ns[cyc]);
                chk("rnd_sign", bus.Adj_SignOut,       e_sgn[cyc]);
                chk("rnd_iv",   bus.Adj_IntervalOut,   e_iv[cyc]);
            end
            for (int i = 0; i < N; i++) begin
                if (val[i] && cyc == done_at[i] + 1)
                    val[i] = 1'b0;
                else if (!val[i] && cyc > done_at[i] + 1 && cyc < RC - 150 && $urandom_range(0, 3) == 0)
                    set_req(i, ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                            $urandom, $urandom_range(0, 999999999), 1'($urandom_range(0, 1)), $urandom);
            end
            if (cyc >= RC - 150) en = '1;
            else if ($urandom_range(0, 15) == 0) en = N'($urandom);
            if (cyc >= free_at) begin
                cand = val & en;
                w = -1;
`ifdef ROUND_ROBIN_EN
                for (int k = 1; k <= N; k++)
                    if (w < 0 && cand[(ptr + k) % N]) w = (ptr + k) % N;
`else
                for (int k = 0; k < N; k++)
                    if (w < 0 && cand[k]) w = k;
`endif
                if (w >= 0) begin
                    oh = '0;
                    oh[w] = 1'b1;
                    if (typ[w] == 2'd3) begin
                        d = cyc + 1;
                        e_err[d] = oh;
                    end else begin
                        e_val[cyc+1] = oh;
                        e_typ[cyc+1] = typ[w];
                        e_sec[cyc+1] = sec[w];
                        e_ns[cyc+1]  = ns[w];
                        e_sgn[cyc+1] = sgn[w];
                        e_iv[cyc+1]  = iv[w];
                        lat = $urandom_range(1, T + 3);
                        if (lat <= T) begin
                            a_plan[cyc+1+lat] = 1'b1;
                            d = cyc + 2 + lat;
                            e_ack[d] = oh;
                        end else begin
                            d = cyc + T + 2;
                            e_err[d] = oh;
                        end
                        win_lo = cyc + 2;
                        win_hi = d - 1;
                    end
                    for (int c = cyc + 1; c <= d; c++) e_grant[c] = oh;
                    done_at[w] = d;
                    free_at = d + 1;
                    ptr = w;
                end
            end
            ack = a_plan[cyc] || ((cyc < win_lo || cyc > win_hi) && $urandom_range(0, 7) == 0);
            tick();
        end
        ack = 1'b0;
        val = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
